lcd4_byte_driver: RTL

- Downstream stage for the countdown timer. It accepts command and character bytes over a valid/ready handshake and drives an HD44780-compatible character LCD in 4-bit mode (RS, EN, DB7..DB4).
- It owns the power-up wait, the fixed init sequence, nibble splitting, EN pulse timing and post-write busy delays, so the timer only has to issue bytes.

---
 rtl/lcd4_byte_driver.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/lcd4_byte_driver.sv
// HD44780 4-bit-mode byte driver: power-up wait, fixed init sequence, nibble
// strobing and post-write busy delays behind a valid/ready byte interface.
module lcd4_byte_driver #(
    parameter int unsigned POWERUP_CYC    = 12000000,
    parameter int unsigned SETUP_CYC      = 2,
    parameter int unsigned EN_HIGH_CYC    = 800,
    parameter int unsigned HOLD_CYC       = 2,
    parameter int unsigned SHORT_WAIT_CYC = 2000,
    parameter int unsigned LONG_WAIT_CYC  = 60000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_rs,
    input  logic [7:0] in_byte,
    output logic       in_ready,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_en,
    output logic [3:0] lcd_d
);
    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAXC = umax(umax(umax(POWERUP_CYC, SETUP_CYC), umax(EN_HIGH_CYC, HOLD_CYC)),
                                        umax(SHORT_WAIT_CYC, LONG_WAIT_CYC));
    localparam int unsigned CW0  = $clog2(MAXC + 1);
    localparam int unsigned CW   = (CW0 > 24) ? CW0 : 24;

    localparam logic [CW-1:0] PWR_LAST   = CW'(POWERUP_CYC - 1);
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LAST    = CW'(EN_HIGH_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] SHORT_LAST = CW'(SHORT_WAIT_CYC - 1);
    localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_WAIT_CYC - 1);

    typedef enum logic [2:0] {PWR_WAIT, SETUP, EN_HI, HOLD, BUSY, IDLE} state_t;

    // Init steps 0..3 are single nibbles (kept in the high half), 4..7 full bytes.
    function automatic logic [7:0] init_byte(input logic [2:0] s);
        case (s)
            3'd0, 3'd1, 3'd2: return 8'h30;
            3'd3:             return 8'h20;
            3'd4:             return 8'h28;
            3'd5:             return 8'h0C;
            3'd6:             return 8'h06;
            default:          return 8'h01;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    step_q, step_d;
    logic [7:0]    byte_q, byte_d;
    logic          rs_q, rs_d;
    logic          hi_q, hi_d;
    logic          single_q, single_d;
    logic          long_q, long_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;
    logic          lcd_rs_q, lcd_rs_d;
    logic          lcd_en_q, lcd_en_d;
    logic [3:0]    lcd_d_q, lcd_d_d;
    logic          ld_init;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= PWR_WAIT;
            cnt_q    <= '0;
            step_q   <= '0;
            byte_q   <= '0;
            rs_q     <= 1'b0;
            hi_q     <= 1'b0;
            single_q <= 1'b0;
            long_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
            lcd_rs_q <= 1'b0;
            lcd_en_q <= 1'b0;
            lcd_d_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            step_q   <= step_d;
            byte_q   <= byte_d;
            rs_q     <= rs_d;
            hi_q     <= hi_d;
            single_q <= single_d;
            long_q   <= long_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            lcd_rs_q <= lcd_rs_d;
            lcd_en_q <= lcd_en_d;
            lcd_d_q  <= lcd_d_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        step_d   = step_q;
        byte_d   = byte_q;
        rs_d     = rs_q;
        hi_d     = hi_q;
        single_d = single_q;
        long_d   = long_q;
        done_d   = done_q;
        lcd_rs_d = lcd_rs_q;
        lcd_d_d  = lcd_d_q;
        ld_init  = 1'b0;

        case (state_q)
            PWR_WAIT: if (cnt_q == PWR_LAST) ld_init = 1'b1;
            SETUP: if (cnt_q == SETUP_LAST) begin
                state_d = EN_HI;
                cnt_d   = '0;
            end
            EN_HI: if (cnt_q == EN_LAST) begin
                state_d = HOLD;
                cnt_d   = '0;
            end
            HOLD: if (cnt_q == HOLD_LAST) begin
                cnt_d = '0;
                if (hi_q && !single_q) begin
                    state_d = SETUP;
                    hi_d    = 1'b0;
                    lcd_d_d = byte_q[3:0];
                end else begin
                    state_d = BUSY;
                    long_d  = single_q || (!rs_q && byte_q <= 8'h03);
                end
            end
            BUSY: if (cnt_q == (long_q ? LONG_LAST : SHORT_LAST)) begin
                cnt_d = '0;
                if (done_q) begin
                    state_d = IDLE;
                end else if (step_q == 3'd7) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    step_d  = step_q + 3'd1;
                    ld_init = 1'b1;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (in_valid && ready_q) begin
                    state_d  = SETUP;
                    byte_d   = in_byte;
                    rs_d     = in_rs;
                    single_d = 1'b0;
                    hi_d     = 1'b1;
                    lcd_rs_d = in_rs;
                    lcd_d_d  = in_byte[7:4];
                end
            end
            default: begin
                state_d = PWR_WAIT;
                cnt_d   = '0;
            end
        endcase

        if (ld_init) begin
            state_d  = SETUP;
            cnt_d    = '0;
            byte_d   = init_byte(step_d);
            single_d = (step_d < 3'd4);
            rs_d     = 1'b0;
            hi_d     = 1'b1;
            lcd_rs_d = 1'b0;
            lcd_d_d  = byte_d[7:4];
        end

        lcd_en_d = (state_d == EN_HI);
        ready_d  = (state_d == IDLE) && done_d;
    end

    assign in_ready  = ready_q;
    assign init_done = done_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_en    = lcd_en_q;
    assign lcd_d     = lcd_d_q;
endmodule
